// File: rtl/alu_8bit.sv
// alu_8bit: 8-bit, eight-operation ALU with a one-cycle registered result.
// The operation is worked out combinationally from a, b and alu_sel. The
// result and the carry/borrow/shift-out flag are captured on every rising
// clk edge. An asynchronous active-low reset clears both outputs at once.
module alu_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] alu_sel,
    output logic [7:0] alu_out,
    output logic       carry_out
);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    alu_op_e    op;
    logic [8:0] sum;
    logic [8:0] diff;
    logic [7:0] result_d;
    logic       carry_d;

    assign op = alu_op_e'(alu_sel);

    // Widen both operands to 9 bits. Bit 8 of the sum is the carry out.
    // Bit 8 of the difference goes high exactly when a < b, so it is the borrow.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
    end

    // Choose the next result and flag from the decoded operation.
    always_comb begin
        // NOTE: every output gets a default before the case. No path can then
        // leave a variable unassigned, so this block can never infer a latch.
        result_d = 8'h00;
        carry_d  = 1'b0;
        case (op)
            OP_ADD: begin
                result_d = sum[7:0];
                carry_d  = sum[8];
            end
            OP_SUB: begin
                result_d = diff[7:0];
                carry_d  = diff[8];
            end
            OP_AND: result_d = a & b;
            OP_OR:  result_d = a | b;
            OP_XOR: result_d = a ^ b;
            OP_NOT: result_d = ~a;
            OP_SHL: begin
                result_d = {a[6:0], 1'b0};
                carry_d  = a[7];
            end
            OP_SHR: begin
                result_d = {1'b0, a[7:1]};
                carry_d  = a[0];
            end
            // Every code is listed above. This branch only catches X/Z on
            // alu_sel in simulation and keeps the outputs at a known value.
            default: begin
                result_d = 8'h00;
                carry_d  = 1'b0;
            end
        endcase
    end

    // Output register: one-cycle latency, cleared at once by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples its input from before the edge, whatever the order
        // of the statements.
        if (!rst_n) begin
            alu_out   <= 8'h00;
            carry_out <= 1'b0;
        end else begin
            alu_out   <= result_d;
            carry_out <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed-vector bench for alu_8bit. Every expected value is
// worked out by hand and stored in the vector table or written inline.
module tb_alu_8bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       carry_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] prev_out;
    logic       prev_c;

    typedef struct {
        string      tag;
        logic [2:0] sel;
        logic [7:0] va;
        logic [7:0] vb;
        logic [7:0] exp_out;
        logic       exp_c;
    } vec_t;

    vec_t vecs[$];

    alu_8bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Drive one vector at the falling edge. Check that the outputs still hold
    // the previous result, then check the new result just after the next
    // rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        a       = v.va;
        b       = v.vb;
        alu_sel = v.sel;
        #1;
        check({v.tag, " hold out"}, alu_out, prev_out);
        check({v.tag, " hold c"}, {7'b0, carry_out}, {7'b0, prev_c});
        @(posedge clk);
        #1;
        check({v.tag, " out"}, alu_out, v.exp_out);
        check({v.tag, " c"}, {7'b0, carry_out}, {7'b0, v.exp_c});
        prev_out = v.exp_out;
        prev_c   = v.exp_c;
    endtask

    initial begin
        // Sweep all eight codes with a = b = 0x37.
        vecs.push_back('{"sweep add", 3'd0, 8'h37, 8'h37, 8'h6E, 1'b0});
        vecs.push_back('{"sweep sub", 3'd1, 8'h37, 8'h37, 8'h00, 1'b0});
        vecs.push_back('{"sweep and", 3'd2, 8'h37, 8'h37, 8'h37, 1'b0});
        vecs.push_back('{"sweep or",  3'd3, 8'h37, 8'h37, 8'h37, 1'b0});
        vecs.push_back('{"sweep xor", 3'd4, 8'h37, 8'h37, 8'h00, 1'b0});
        vecs.push_back('{"sweep not", 3'd5, 8'h37, 8'h37, 8'hC8, 1'b0});
        vecs.push_back('{"sweep shl", 3'd6, 8'h37, 8'h37, 8'h6E, 1'b0});
        vecs.push_back('{"sweep shr", 3'd7, 8'h37, 8'h37, 8'h1B, 1'b1});
        // Overflow and borrow boundaries.
        vecs.push_back('{"add ff+01", 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1});
        vecs.push_back('{"add 80+80", 3'd0, 8'h80, 8'h80, 8'h00, 1'b1});
        vecs.push_back('{"sub 00-01", 3'd1, 8'h00, 8'h01, 8'hFF, 1'b1});
        vecs.push_back('{"sub 10-01", 3'd1, 8'h10, 8'h01, 8'h0F, 1'b0});
        // Shift-out cases.
        vecs.push_back('{"shl 81",    3'd6, 8'h81, 8'h00, 8'h02, 1'b1});
        vecs.push_back('{"shr 81",    3'd7, 8'h81, 8'hFF, 8'h40, 1'b1});
        // Further patterns, one new input set every cycle.
        vecs.push_back('{"add 12+34", 3'd0, 8'h12, 8'h34, 8'h46, 1'b0});
        vecs.push_back('{"and f0 3c", 3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0});
        vecs.push_back('{"or a5 0f",  3'd3, 8'hA5, 8'h0F, 8'hAF, 1'b0});
        vecs.push_back('{"xor aa ff", 3'd4, 8'hAA, 8'hFF, 8'h55, 1'b0});
        vecs.push_back('{"not 00",    3'd5, 8'h00, 8'h5A, 8'hFF, 1'b0});
        vecs.push_back('{"shl 40",    3'd6, 8'h40, 8'h00, 8'h80, 1'b0});
        vecs.push_back('{"sub c3-3c", 3'd1, 8'hC3, 8'h3C, 8'h87, 1'b0});

        // Hold reset across clock edges while the inputs are non-zero.
        rst_n   = 1'b0;
        a       = 8'h5A;
        b       = 8'h33;
        alu_sel = 3'd0;
        #1;
        check("reset t0 out", alu_out, 8'h00);
        check("reset t0 c", {7'b0, carry_out}, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset held out", alu_out, 8'h00);
        check("reset held c", {7'b0, carry_out}, 8'h00);

        // Release reset. The very first edge must register 0x5A + 0x33.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first edge out", alu_out, 8'h8D);
        check("first edge c", {7'b0, carry_out}, 8'h00);
        prev_out = 8'h8D;
        prev_c   = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Mid-sequence reset between edges. The last result was 0x87, and the
        // outputs must clear without waiting for an edge.
        @(negedge clk);
        a       = 8'hFF;
        b       = 8'h01;
        alu_sel = 3'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out", alu_out, 8'h00);
        check("async reset c", {7'b0, carry_out}, 8'h00);
        @(posedge clk);
        #1;
        check("pending discard out", alu_out, 8'h00);
        check("pending discard c", {7'b0, carry_out}, 8'h00);

        // Release reset with a new operation: 0x00 - 0x01 gives 0xFF, borrow 1.
        @(negedge clk);
        a       = 8'h00;
        b       = 8'h01;
        alu_sel = 3'd1;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        check("post reset out", alu_out, 8'hFF);
        check("post reset c", {7'b0, carry_out}, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_8bit.md
ALU_8BIT -- requirements
Module: alu_8bit

Interface
REQ-001 The module SHALL have no parameters; the datapath width is fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  8  operand A, unsigned.
REQ-005 b  input  8  operand B, unsigned.
REQ-006 alu_sel  input  3  operation select; sampled every rising clk edge.
REQ-007 alu_out  output  8  registered result.
REQ-008 carry_out  output  1  registered carry/borrow/shift-out flag.

Function
REQ-009 The module SHALL compute a combinational result from a, b and alu_sel, and register it into alu_out and carry_out on every rising clk edge while rst_n is high.
REQ-010 Latency SHALL be exactly 1 clock: inputs present before edge N appear on the outputs after edge N; the outputs SHALL hold between edges.
REQ-011 The module SHALL have no handshake and no enable; a new operation SHALL be accepted every cycle.
REQ-012 alu_sel=000 ADD: alu_out = (a+b) mod 256; carry_out = bit 8 of the 9-bit sum.
REQ-013 alu_sel=001 SUB: alu_out = (a-b) mod 256; carry_out = 1 when a<b (borrow), otherwise 0.
REQ-014 alu_sel=010 AND: alu_out = a & b; carry_out = 0.
REQ-015 alu_sel=011 OR: alu_out = a | b; carry_out = 0.
REQ-016 alu_sel=100 XOR: alu_out = a ^ b; carry_out = 0.
REQ-017 alu_sel=101 NOT: alu_out = ~a; b is ignored; carry_out = 0.
REQ-018 alu_sel=110 SHL: alu_out = {a[6:0],0}; carry_out = a[7]; b is ignored.
REQ-019 alu_sel=111 SHR (logical): alu_out = {0,a[7:1]}; carry_out = a[0]; b is ignored.
REQ-020 All eight alu_sel codes are defined; an X/Z on alu_sel SHALL NOT be relied upon, and synthesis SHALL produce a full case with no latches.
REQ-021 Boundary cases: 0xFF+0x01 SHALL give 0x00 with carry 1; 0x00-0x01 SHALL give 0xFF with carry 1; equal operands under SUB SHALL give 0x00 with carry 0.

Reset
REQ-022 When rst_n is low, alu_out SHALL be forced to 0x00 and carry_out to 0 immediately, without waiting for clk.
REQ-023 While rst_n is low, the outputs SHALL stay at 0 regardless of clk or the inputs.
REQ-024 On the first rising clk edge after rst_n goes high, the module SHALL register the current operation; there SHALL be no extra recovery cycle.
REQ-025 If reset is asserted in the middle of a sequence, the pending result SHALL be discarded.

Verification
REQ-026 Reset: drive rst_n=0 between clk edges -> alu_out=0x00 and carry_out=0 with no edge required.
REQ-027 Sweep all eight alu_sel codes with a=b=0x37, one per cycle -> after each edge the outputs SHALL be:
- ADD: 0x6E/c0
- SUB: 0x00/c0
- AND: 0x37/c0
- OR: 0x37/c0
- XOR: 0x00/c0
- NOT: 0xC8/c0
- SHL: 0x6E/c0
- SHR: 0x1B/c1
REQ-028 Overflow: ADD with a=0xFF, b=0x01 -> 0x00, carry 1; ADD with a=0x80, b=0x80 -> 0x00, carry 1.
REQ-029 Borrow: SUB with a=0x00, b=0x01 -> 0xFF, carry 1; SUB with a=0x10, b=0x01 -> 0x0F, carry 0.
REQ-030 Shift-out: SHL with a=0x81 -> 0x02, carry 1; SHR with a=0x81 -> 0x40, carry 1.
REQ-031 Latency and mid-reset: change the inputs each cycle -> each output SHALL match the inputs from the previous edge; assert rst_n low mid-sequence -> the outputs SHALL become 0 at once, and the first edge after release SHALL produce the current operation's result.
